// File: rtl/scan_sequencer.sv
// scan_sequencer
//   Round-robin scan controller for a downstream 2-to-4 one-hot decoder.
//   It steps through the four channels in ascending order and holds each one
//   enabled for max(dwell,1) cycles. An optional blanking gap of `blank`
//   cycles with en low can separate channels. Channels can be skipped by
//   mask. The block runs either continuously or for a single pass.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   start       : begin scanning (ignored while busy or when all channels masked)
//   stop        : abort scanning, priority over start
//   mode_single : 1 = one pass then idle, 0 = continuous (sampled at each wrap)
//   dwell       : enabled cycles per channel, 0 treated as 1
//   blank       : en-low cycles between channels, 0 = no gap
//   skip_mask   : bit i = 1 skips channel i
//   a, b        : channel select MSB / LSB to the decoder
//   en          : decoder enable
//   busy        : high whenever the sequencer is not idle
//   pass_done   : one-cycle pulse at the end of every completed pass
module scan_sequencer #(
  parameter int DWELL_W = 8,
  parameter int BLANK_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_single,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank,
  input  logic [3:0]         skip_mask,
  output logic               a,
  output logic               b,
  output logic               en,
  output logic               busy,
  output logic               pass_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [1:0]         nxt_q, nxt_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               pass_done_q, pass_done_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;

  // Returns {found, index} of the first unmasked channel after `cur`,
  // searching cur+1, cur+2, cur+3 and finally cur itself (modulo 4).
  // Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [2:0] next_unmasked(input logic [1:0] cur,
                                               input logic [3:0] mask);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      cand = cur + i[1:0];
      if (!mask[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [DWELL_W-1:0] dwell_load;
  logic [2:0]         nu_cur;
  logic [2:0]         nu_first;
  logic               wrap;

  assign dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign nu_cur     = next_unmasked(ch_q, skip_mask);
  // Searching forward from channel 3 yields the lowest unmasked channel.
  assign nu_first   = next_unmasked(2'd3, skip_mask);
  assign wrap       = (nu_cur[1:0] <= ch_q);

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    nxt_d       = nxt_q;
    en_d        = en_q;
    busy_d      = busy_q;
    pass_done_d = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    blank_cnt_d = blank_cnt_q;

    if (stop) begin
      state_d     = IDLE;
      ch_d        = 2'd0;
      en_d        = 1'b0;
      busy_d      = 1'b0;
      dwell_cnt_d = '0;
      blank_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (skip_mask != 4'b1111)) begin
            state_d     = ACTIVE;
            ch_d        = nu_first[1:0];
            en_d        = 1'b1;
            busy_d      = 1'b1;
            dwell_cnt_d = dwell_load;
          end
        end

        ACTIVE: begin
          if (dwell_cnt_q <= DWELL_W'(1)) begin
            if (!nu_cur[2]) begin
              // Every channel got masked mid-scan: nothing left to visit.
              state_d = IDLE;
              ch_d    = 2'd0;
              en_d    = 1'b0;
              busy_d  = 1'b0;
            end else if (wrap && mode_single) begin
              state_d     = IDLE;
              ch_d        = 2'd0;
              en_d        = 1'b0;
              busy_d      = 1'b0;
              pass_done_d = 1'b1;
            end else begin
              pass_done_d = wrap;
              if (blank == '0) begin
                ch_d        = nu_cur[1:0];
                dwell_cnt_d = dwell_load;
              end else begin
                // Select stays on the old channel during the gap so it
                // only moves when en rises again.
                state_d     = BLANK;
                en_d        = 1'b0;
                nxt_d       = nu_cur[1:0];
                blank_cnt_d = blank;
              end
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end
        end

        BLANK: begin
          if (blank_cnt_q <= BLANK_W'(1)) begin
            state_d     = ACTIVE;
            ch_d        = nxt_q;
            en_d        = 1'b1;
            dwell_cnt_d = dwell_load;
          end else begin
            blank_cnt_d = blank_cnt_q - BLANK_W'(1);
          end
        end

        default: begin
          state_d = IDLE;
          ch_d    = 2'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= 2'd0;
      nxt_q       <= 2'd0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
      dwell_cnt_q <= '0;
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      nxt_q       <= nxt_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      pass_done_q <= pass_done_d;
      dwell_cnt_q <= dwell_cnt_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  assign a         = ch_q[1];
  assign b         = ch_q[0];
  assign en        = en_q;
  assign busy      = busy_q;
  assign pass_done = pass_done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, mode_single;
  logic [7:0] dwell;
  logic [3:0] blank;
  logic [3:0] skip_mask;
  logic       a, b, en, busy, pass_done;

  int errors = 0;
  int checks = 0;

  scan_sequencer #(.DWELL_W(8), .BLANK_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .mode_single (mode_single),
    .dwell       (dwell),
    .blank       (blank),
    .skip_mask   (skip_mask),
    .a           (a),
    .b           (b),
    .en          (en),
    .busy        (busy),
    .pass_done   (pass_done)
  );

  always #5 clk = ~clk;

  // exp packs {a, b, en, busy, pass_done}
  typedef struct {
    logic       start;
    logic       stop;
    logic       single;
    logic [7:0] dwell;
    logic [3:0] blank;
    logic [3:0] mask;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] e(input int ch, input bit en_e,
                                   input bit busy_e, input bit pd_e);
    logic [1:0] c;
    c = ch[1:0];
    return {c, en_e, busy_e, pd_e};
  endfunction

  task automatic add(input logic st, input logic sp, input logic sg,
                     input logic [7:0] dw, input logic [3:0] bl,
                     input logic [3:0] mk, input logic [4:0] ex);
    vec_t v;
    v.start = st; v.stop = sp; v.single = sg;
    v.dwell = dw; v.blank = bl; v.mask = mk; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {a, b, en, busy, pass_done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {a,b,en,busy,pd}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic sg,
                       input logic [7:0] dw, input logic [3:0] bl,
                       input logic [3:0] mk);
    @(negedge clk);
    start = st; stop = sp; mode_single = sg;
    dwell = dw; blank = bl; skip_mask = mk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; mode_single = 0;
    dwell = 8'd1; blank = 4'd0; skip_mask = 4'd0;

    // Continuous, dwell 3, no gap: 3 cycles per channel, pass_done every 12.
    // A start at offset 7 lands while busy and must be ignored.
    for (int j = 0; j <= 24; j++)
      add((j == 0) || (j == 7), 1'b0, 1'b0, 8'd3, 4'd0, 4'b0000,
          e((j / 3) % 4, 1'b1, 1'b1, (j == 12) || (j == 24)));
    // stop and start together: stop wins, no pass_done
    add(1'b1, 1'b1, 1'b0, 8'd3, 4'd0, 4'b0000, e(0, 0, 0, 0));
    add(1'b0, 1'b0, 1'b0, 8'd3, 4'd0, 4'b0000, e(0, 0, 0, 0));

    // Single pass, dwell 2, blank 1, mask 0101 -> channels 1 and 3
    add(1'b1, 1'b0, 1'b1, 8'd2, 4'd1, 4'b0101, e(1, 1, 1, 0));
    add(1'b0, 1'b0, 1'b1, 8'd2, 4'd1, 4'b0101, e(1, 1, 1, 0));
    add(1'b0, 1'b0, 1'b1, 8'd2, 4'd1, 4'b0101, e(1, 0, 1, 0));
    add(1'b0, 1'b0, 1'b1, 8'd2, 4'd1, 4'b0101, e(3, 1, 1, 0));
    add(1'b0, 1'b0, 1'b1, 8'd2, 4'd1, 4'b0101, e(3, 1, 1, 0));
    add(1'b0, 1'b0, 1'b1, 8'd2, 4'd1, 4'b0101, e(0, 0, 0, 1));
    add(1'b0, 1'b0, 1'b1, 8'd2, 4'd1, 4'b0101, e(0, 0, 0, 0));

    // All channels masked: start ignored
    add(1'b1, 1'b0, 1'b0, 8'd2, 4'd0, 4'b1111, e(0, 0, 0, 0));
    add(1'b0, 1'b0, 1'b0, 8'd2, 4'd0, 4'b1111, e(0, 0, 0, 0));

    // dwell 0 -> 1, only channel 0, blank 2: en 1,0,0 with pass_done each wrap
    add(1'b1, 1'b0, 1'b0, 8'd0, 4'd2, 4'b1110, e(0, 1, 1, 0));
    for (int j = 1; j <= 9; j++)
      add(1'b0, 1'b0, 1'b0, 8'd0, 4'd2, 4'b1110,
          e(0, (j % 3) == 0, 1'b1, (j % 3) == 1));
    add(1'b0, 1'b1, 1'b0, 8'd0, 4'd2, 4'b1110, e(0, 0, 0, 0));

    // Reset state
    #2;
    check("reset_state", e(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].single,
            vecs[i].dwell, vecs[i].blank, vecs[i].mask);
      check($sformatf("vec[%0d]", i), vecs[i].exp);
    end

    // Asynchronous reset during ACTIVE on channel 2
    drive(1'b1, 1'b0, 1'b0, 8'd3, 4'd0, 4'b0000);
    check("rst_seq_ch0", e(0, 1, 1, 0));
    for (int j = 1; j <= 6; j++)
      drive(1'b0, 1'b0, 1'b0, 8'd3, 4'd0, 4'b0000);
    check("rst_seq_ch2", e(2, 1, 1, 0));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_clear", e(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'd3, 4'd0, 4'b0011);
    check("rst_restart_lowest", e(2, 1, 1, 0));
    drive(1'b0, 1'b1, 1'b0, 8'd3, 4'd0, 4'b0011);
    check("rst_seq_stop", e(0, 0, 0, 0));

    // Mid-scan mask and dwell change during channel 0
    drive(1'b1, 1'b0, 1'b0, 8'd4, 4'd0, 4'b0000);
    check("mid_ch0_a", e(0, 1, 1, 0));
    drive(1'b0, 1'b0, 1'b0, 8'd4, 4'd0, 4'b0000);
    check("mid_ch0_b", e(0, 1, 1, 0));
    drive(1'b0, 1'b0, 1'b0, 8'd1, 4'd0, 4'b1011);
    check("mid_ch0_c", e(0, 1, 1, 0));
    drive(1'b0, 1'b0, 1'b0, 8'd1, 4'd0, 4'b1011);
    check("mid_ch0_d", e(0, 1, 1, 0));
    drive(1'b0, 1'b0, 1'b0, 8'd1, 4'd0, 4'b1011);
    check("mid_ch2_first", e(2, 1, 1, 0));
    drive(1'b0, 1'b0, 1'b0, 8'd1, 4'd0, 4'b1011);
    check("mid_ch2_wrap1", e(2, 1, 1, 1));
    drive(1'b0, 1'b0, 1'b0, 8'd1, 4'd0, 4'b1011);
    check("mid_ch2_wrap2", e(2, 1, 1, 1));
    drive(1'b0, 1'b1, 1'b0, 8'd1, 4'd0, 4'b1011);
    check("mid_stop", e(0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
